// File: rtl/seq_shift_add_multiplier.sv
// Iterative WIDTH x WIDTH shift-and-add multiplier: one row of AND + adder cells
// reused over WIDTH cycles, with valid/ready handshakes and per-op signed mode.
module seq_shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic                   is_signed,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     product,
    output logic                   busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // |x| of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits as an unsigned WIDTH value.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] one;
        one = {{(WIDTH-1){1'b0}}, 1'b1};
        if (x[WIDTH-1]) begin
            magnitude = ~x + one;
        end else begin
            magnitude = x;
        end
    endfunction

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic                 neg_q, neg_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d;
    logic                 busy_q, busy_d;

    logic [WIDTH:0]       sum_s;
    logic [2*WIDTH-1:0]   row_s;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign busy      = busy_q;

    // Row step datapath, next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        q_d         = q_q;
        acc_d       = acc_q;
        neg_d       = neg_q;
        cnt_d       = cnt_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;

        sum_s = {1'b0, acc_q} + {1'b0, m_q & {WIDTH{q_q[0]}}};
        // Shifted row: the fresh sum's LSB drops into the top of the multiplier register.
        row_s = {sum_s, q_q[WIDTH-1:1]};

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    m_d        = is_signed ? magnitude(a) : a;
                    q_d        = is_signed ? magnitude(b) : b;
                    neg_d      = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d      = ZERO_W;
                    cnt_d      = CNT_ZERO;
                    state_d    = S_CALC;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_CALC: begin
                acc_d = row_s[2*WIDTH-1:WIDTH];
                q_d   = row_s[WIDTH-1:0];
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    product_d   = neg_q ? (ZERO_2W - row_s) : row_s;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    state_d     = S_CALC;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d     = S_DONE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            m_q         <= ZERO_W;
            q_q         <= ZERO_W;
            acc_q       <= ZERO_W;
            neg_q       <= 1'b0;
            cnt_q       <= CNT_ZERO;
            product_q   <= ZERO_2W;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            q_q         <= q_d;
            acc_q       <= acc_d;
            neg_q       <= neg_d;
            cnt_q       <= cnt_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

endmodule
